// File: rtl/dht11_pkg.sv
// DHT11 reader shared types: FSM states, frame layout, timing helpers.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_ACK,
        ST_ACK_LOW,
        ST_ACK_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_CHECK
    } dht_state_e;

    localparam int unsigned FRAME_BITS = 40;

    localparam int unsigned BYTE_HUM_INT  = 0;
    localparam int unsigned BYTE_HUM_DEC  = 1;
    localparam int unsigned BYTE_TEMP_INT = 2;
    localparam int unsigned BYTE_TEMP_DEC = 3;
    localparam int unsigned BYTE_CSUM     = 4;

    localparam int unsigned FILTER_LEN = 8;

    function automatic int unsigned us_to_cycles(
        input longint unsigned us,
        input longint unsigned clk_hz
    );
        longint unsigned cyc;
        cyc = (us * clk_hz) / 64'd1_000_000;
        return cyc[31:0];
    endfunction

    // Bytes arrive MSB first, so byte 0 sits at the top of the frame.
    function automatic logic [7:0] frame_byte(
        input logic [FRAME_BITS-1:0] frame,
        input int unsigned           idx
    );
        logic [FRAME_BITS-1:0] s;
        s = frame << (8 * idx);
        return s[FRAME_BITS-1 -: 8];
    endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// DHT11 bus input conditioning: 2-FF synchronizer, rise/fall pulses.
// Define DHT11_GLITCH_FILTER_EN to add an 8-sample persistence filter.
module dht11_line_sync
    import dht11_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       level_q;

    // Bus idles high through the pull-up, so reset to 1 avoids a fake edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

`ifdef DHT11_GLITCH_FILTER_EN
    logic [2:0] run_q;
    logic       filt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q  <= '0;
            filt_q <= 1'b1;
        end else if (sync_q[1] != filt_q) begin
            if (run_q == 3'(FILTER_LEN - 1)) begin
                filt_q <= sync_q[1];
                run_q  <= '0;
            end else begin
                run_q <= run_q + 3'd1;
            end
        end else begin
            run_q <= '0;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/dht11_reader.sv
// DHT11 single-wire master: start pulse, response timing, frame decode.
// Optional DHT11_GLITCH_FILTER_EN enables the input glitch filter.
module dht11_reader
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
    parameter int unsigned SAMPLE_PERIOD_MS = 2000,
    parameter int unsigned START_LOW_US     = 18000,
    parameter int unsigned BIT_THRESH_US    = 50,
    parameter int unsigned TIMEOUT_US       = 200,
    parameter int unsigned FAIL_LIMIT       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dht_data_in,
    output logic       dht_data_oe,
    output logic [7:0] humidity_int,
    output logic [7:0] humidity_dec,
    output logic [7:0] temp_int,
    output logic [7:0] temp_dec,
    output logic       humidity_valid,
    output logic       data_update,
    output logic       sensor_error
);

    localparam longint unsigned HZ = 64'(CLK_FREQ_HZ);

    localparam int unsigned SAMPLE_CYC =
        us_to_cycles(64'(SAMPLE_PERIOD_MS) * 64'd1000, HZ);
    localparam int unsigned START_CYC =
        us_to_cycles(64'(START_LOW_US), HZ);
    localparam int unsigned BIT_CYC =
        us_to_cycles(64'(BIT_THRESH_US), HZ);
    localparam int unsigned TIMEOUT_CYC =
        us_to_cycles(64'(TIMEOUT_US), HZ);

    localparam int unsigned FAIL_W   = $clog2(FAIL_LIMIT + 1);
    localparam logic [5:0]  LAST_IDX = 6'(FRAME_BITS - 1);

    logic line_level;
    logic line_rise;
    logic line_fall;

    dht11_line_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (dht_data_in),
        .level (line_level),
        .rise  (line_rise),
        .fall  (line_fall)
    );

    dht_state_e            state_q, state_d;
    logic [31:0]           tmr_q, tmr_d;
    logic [5:0]            idx_q, idx_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  timeout;
    logic                  phase_end;
    logic                  bit_one;

    logic [7:0]        b_hum_int, b_hum_dec;
    logic [7:0]        b_temp_int, b_temp_dec;
    logic [7:0]        b_csum, csum;
    logic              good_frame, bad_frame;
    logic [FAIL_W-1:0] fail_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    assign phase_end = (tmr_q == TIMEOUT_CYC - 1);
    // The rise cycle itself is part of the high phase, hence the +1.
    assign bit_one   = ((tmr_q + 32'd1) >= BIT_CYC);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        timeout = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tmr_q == SAMPLE_CYC - 1) state_d = ST_START;
            end
            ST_START: begin
                if (tmr_q == START_CYC - 1) state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (line_fall)      state_d = ST_ACK_LOW;
                else if (phase_end) timeout = 1'b1;
            end
            ST_ACK_LOW: begin
                if (line_rise)      state_d = ST_ACK_HIGH;
                else if (phase_end) timeout = 1'b1;
            end
            ST_ACK_HIGH: begin
                if (line_fall) begin
                    state_d = ST_BIT_LOW;
                    idx_d   = '0;
                end else if (phase_end) begin
                    timeout = 1'b1;
                end
            end
            ST_BIT_LOW: begin
                if (line_rise)      state_d = ST_BIT_HIGH;
                else if (phase_end) timeout = 1'b1;
            end
            ST_BIT_HIGH: begin
                if (line_fall) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], bit_one};
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = ST_BIT_LOW;
                    end
                end else if (phase_end) begin
                    timeout = 1'b1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (timeout) state_d = ST_IDLE;
        tmr_d = (state_d != state_q) ? '0 : tmr_q + 32'd1;
    end

    assign dht_data_oe = (state_q == ST_START);

    assign b_hum_int  = frame_byte(shreg_q, BYTE_HUM_INT);
    assign b_hum_dec  = frame_byte(shreg_q, BYTE_HUM_DEC);
    assign b_temp_int = frame_byte(shreg_q, BYTE_TEMP_INT);
    assign b_temp_dec = frame_byte(shreg_q, BYTE_TEMP_DEC);
    assign b_csum     = frame_byte(shreg_q, BYTE_CSUM);

    assign csum = b_hum_int + b_hum_dec + b_temp_int + b_temp_dec;

    assign good_frame = (state_q == ST_CHECK) && (csum == b_csum);
    assign bad_frame  = ((state_q == ST_CHECK) && (csum != b_csum))
                      || timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            humidity_int   <= '0;
            humidity_dec   <= '0;
            temp_int       <= '0;
            temp_dec       <= '0;
            humidity_valid <= 1'b0;
            data_update    <= 1'b0;
            sensor_error   <= 1'b0;
            fail_q         <= '0;
        end else begin
            data_update  <= good_frame;
            sensor_error <= bad_frame;
            if (good_frame) begin
                humidity_int   <= b_hum_int;
                humidity_dec   <= b_hum_dec;
                temp_int       <= b_temp_int;
                temp_dec       <= b_temp_dec;
                humidity_valid <= 1'b1;
                fail_q         <= '0;
            end else if (bad_frame) begin
                if (fail_q != FAIL_W'(FAIL_LIMIT)) begin
                    fail_q <= fail_q + 1'b1;
                end
                // Drop valid on the failure that reaches the limit.
                if (fail_q >= FAIL_W'(FAIL_LIMIT - 1)) begin
                    humidity_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader with a behavioural DHT11 sensor model.
// Runs at 1 MHz so one clock is one microsecond.
module tb_dht11_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sens;
    logic       dht_data_in;
    logic       dht_data_oe;
    logic [7:0] humidity_int;
    logic [7:0] humidity_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       humidity_valid;
    logic       data_update;
    logic       sensor_error;

    int n_cmp = 0;
    int n_bad = 0;
    int upd_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    assign dht_data_in = dht_data_oe ? 1'b0 : sens;

    dht11_reader #(
        .CLK_FREQ_HZ      (1_000_000),
        .SAMPLE_PERIOD_MS (1),
        .START_LOW_US     (100),
        .BIT_THRESH_US    (50),
        .TIMEOUT_US       (200),
        .FAIL_LIMIT       (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dht_data_in    (dht_data_in),
        .dht_data_oe    (dht_data_oe),
        .humidity_int   (humidity_int),
        .humidity_dec   (humidity_dec),
        .temp_int       (temp_int),
        .temp_dec       (temp_dec),
        .humidity_valid (humidity_valid),
        .data_update    (data_update),
        .sensor_error   (sensor_error)
    );

    always @(negedge clk) begin
        if (data_update) upd_cnt++;
        if (sensor_error) err_cnt++;
        if (data_update && sensor_error) both_cnt++;
    end

    task automatic drive(input logic v, input int n);
        sens = v;
        repeat (n) @(negedge clk);
    endtask

    // Sensor model: waits for the host start pulse, then answers with
    // ack low/high and 40 bits. w0/w1 are high widths for 0/1 bits.
    task automatic send_frame(
        input  logic [39:0] fr,
        input  int          w0,
        input  int          w1,
        input  int          glitch_bit,
        input  int          rst_bit,
        output int          oe_cyc
    );
        int k;
        k = 0;
        oe_cyc = 0;
        while (!dht_data_oe && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (dht_data_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL start_seen: oe=%b want 1 after %0d cycles",
                     dht_data_oe, k);
            return;
        end
        while (dht_data_oe && oe_cyc < 3000) begin
            oe_cyc++;
            @(negedge clk);
        end
        drive(1'b1, 20);
        drive(1'b0, 80);
        drive(1'b1, 80);
        for (int i = 0; i < 40; i++) begin
            if (i == rst_bit) begin
                rst_n = 1'b0;
                sens  = 1'b1;
                @(negedge clk);
                n_cmp++;
                if (dht_data_oe !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rst_oe: got %b want 0", dht_data_oe);
                end
                n_cmp++;
                if ({humidity_int, humidity_dec, temp_int, temp_dec}
                    !== 32'h0) begin
                    n_bad++;
                    $display("FAIL rst_data: got %h %h %h %h want 0",
                             humidity_int, humidity_dec, temp_int, temp_dec);
                end
                n_cmp++;
                if (humidity_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rst_valid: got %b want 0", humidity_valid);
                end
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            drive(1'b0, 50);
            if (i == glitch_bit) begin
                drive(1'b1, 30);
                drive(1'b0, 3);
                drive(1'b1, 37);
            end else begin
                drive(1'b1, fr[39-i] ? w1 : w0);
            end
        end
        drive(1'b0, 50);
        sens = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        sens  = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (dht_data_oe !== 1'b0) begin
            n_bad++; $display("FAIL reset_oe: got %b want 0", dht_data_oe);
        end
        n_cmp++;
        if ({humidity_int, humidity_dec, temp_int, temp_dec} !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: got %h%h%h%h want 0",
                              humidity_int, humidity_dec, temp_int, temp_dec);
        end
        n_cmp++;
        if ({humidity_valid, data_update, sensor_error} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b%b%b want 000",
                              humidity_valid, data_update, sensor_error);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_good_frame;
        int oe_cyc, u0, e0;
        u0 = upd_cnt;
        e0 = err_cnt;
        send_frame(40'h3C_00_19_00_55, 26, 70, -1, -1, oe_cyc);
        n_cmp++;
        if (oe_cyc !== 100) begin
            n_bad++; $display("FAIL good_oe_len: got %0d want 100", oe_cyc);
        end
        n_cmp++;
        if (humidity_int !== 8'd60) begin
            n_bad++; $display("FAIL good_hum: got %0d want 60", humidity_int);
        end
        n_cmp++;
        if (temp_int !== 8'd25) begin
            n_bad++; $display("FAIL good_temp: got %0d want 25", temp_int);
        end
        n_cmp++;
        if ({humidity_dec, temp_dec} !== 16'h0) begin
            n_bad++; $display("FAIL good_dec: got %h %h want 0",
                              humidity_dec, temp_dec);
        end
        n_cmp++;
        if (humidity_valid !== 1'b1) begin
            n_bad++; $display("FAIL good_valid: got %b want 1", humidity_valid);
        end
        n_cmp++;
        if (upd_cnt - u0 !== 1) begin
            n_bad++; $display("FAIL good_update: got %0d want 1", upd_cnt - u0);
        end
        n_cmp++;
        if (err_cnt - e0 !== 0) begin
            n_bad++; $display("FAIL good_error: got %0d want 0", err_cnt - e0);
        end
    endtask

    task automatic test_bad_checksum;
        int oe_cyc, u0, e0;
        logic [39:0] fr;
        logic        want_v;
        for (int n = 1; n <= 3; n++) begin
            u0 = upd_cnt;
            e0 = err_cnt;
            fr = (n == 1) ? 40'h3C_00_19_00_54 : 40'h50_01_20_02_74;
            want_v = (n < 3);
            send_frame(fr, 26, 70, -1, -1, oe_cyc);
            n_cmp++;
            if (err_cnt - e0 !== 1 || upd_cnt - u0 !== 0) begin
                n_bad++; $display("FAIL bad%0d_pulses: err %0d upd %0d want 1 0",
                                  n, err_cnt - e0, upd_cnt - u0);
            end
            n_cmp++;
            if (humidity_int !== 8'd60 || temp_int !== 8'd25) begin
                n_bad++; $display("FAIL bad%0d_hold: got %0d %0d want 60 25",
                                  n, humidity_int, temp_int);
            end
            n_cmp++;
            if (humidity_valid !== want_v) begin
                n_bad++; $display("FAIL bad%0d_valid: got %b want %b",
                                  n, humidity_valid, want_v);
            end
        end
    endtask

    task automatic test_no_sensor;
        int k, n, g;
        k = 0;
        while (!dht_data_oe && k < 3000) begin @(negedge clk); k++; end
        k = 0;
        while (dht_data_oe && k < 3000) begin @(negedge clk); k++; end
        n = 0;
        while (!sensor_error && n < 1000) begin n++; @(negedge clk); end
        n_cmp++;
        if (n !== 200) begin
            n_bad++; $display("FAIL nosens_timeout: got %0d want 200", n);
        end
        n_cmp++;
        if (dht_data_oe !== 1'b0 || humidity_int !== 8'd60) begin
            n_bad++; $display("FAIL nosens_idle: oe %b hum %0d want 0 60",
                              dht_data_oe, humidity_int);
        end
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!dht_data_oe && g < 3000);
        n_cmp++;
        if (g !== 1000) begin
            n_bad++; $display("FAIL nosens_period: got %0d want 1000", g);
        end
        k = 0;
        while (!sensor_error && k < 600) begin @(negedge clk); k++; end
        n_cmp++;
        if (sensor_error !== 1'b1) begin
            n_bad++; $display("FAIL nosens_retry: got %b want 1", sensor_error);
        end
    endtask

    task automatic test_reset_mid_frame;
        int oe_cyc;
        send_frame(40'h3C_00_19_00_55, 26, 70, -1, 20, oe_cyc);
        send_frame(40'h2D_00_17_03_47, 26, 70, -1, -1, oe_cyc);
        n_cmp++;
        if ({humidity_int, humidity_dec, temp_int, temp_dec}
            !== 32'h2D_00_17_03) begin
            n_bad++; $display("FAIL rstmid_data: got %h%h%h%h want 2d001703",
                              humidity_int, humidity_dec, temp_int, temp_dec);
        end
        n_cmp++;
        if (humidity_valid !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_valid: got %b want 1", humidity_valid);
        end
    endtask

    task automatic test_threshold;
        int oe_cyc, u0;
        u0 = upd_cnt;
        send_frame(40'h41_00_1E_05_64, 49, 50, -1, -1, oe_cyc);
        n_cmp++;
        if ({humidity_int, humidity_dec, temp_int, temp_dec}
            !== 32'h41_00_1E_05) begin
            n_bad++; $display("FAIL thresh_data: got %h%h%h%h want 41001e05",
                              humidity_int, humidity_dec, temp_int, temp_dec);
        end
        n_cmp++;
        if (upd_cnt - u0 !== 1) begin
            n_bad++; $display("FAIL thresh_update: got %0d want 1", upd_cnt - u0);
        end
    endtask

    task automatic test_glitch;
        int oe_cyc, u0, e0;
        u0 = upd_cnt;
        e0 = err_cnt;
        send_frame(40'h3C_00_19_00_55, 26, 70, 2, -1, oe_cyc);
`ifdef DHT11_GLITCH_FILTER_EN
        n_cmp++;
        if (upd_cnt - u0 !== 1 || err_cnt - e0 !== 0) begin
            n_bad++; $display("FAIL glitch_pulses: upd %0d err %0d want 1 0",
                              upd_cnt - u0, err_cnt - e0);
        end
        n_cmp++;
        if (humidity_int !== 8'd60 || temp_int !== 8'd25) begin
            n_bad++; $display("FAIL glitch_data: got %0d %0d want 60 25",
                              humidity_int, temp_int);
        end
`else
        n_cmp++;
        if (upd_cnt - u0 !== 0 || err_cnt - e0 !== 1) begin
            n_bad++; $display("FAIL glitch_pulses: upd %0d err %0d want 0 1",
                              upd_cnt - u0, err_cnt - e0);
        end
        n_cmp++;
        if (humidity_int !== 8'd65 || temp_int !== 8'd30) begin
            n_bad++; $display("FAIL glitch_hold: got %0d %0d want 65 30",
                              humidity_int, temp_int);
        end
`endif
        n_cmp++;
        if (humidity_valid !== 1'b1) begin
            n_bad++; $display("FAIL glitch_valid: got %b want 1", humidity_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sens  = 1'b1;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_no_sensor();
        test_reset_mid_frame();
        test_threshold();
        test_glitch();
        n_cmp++;
        if (both_cnt !== 0) begin
            n_bad++; $display("FAIL pulse_overlap: got %0d want 0", both_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
